// File: rtl/policy_lookup_if.sv
// Query/result handshake bundle for policy_lookup.
// r_value is present only when POLICY_VALUE_OUT_EN is defined.
interface policy_lookup_if #(
    parameter int NUM_STATES = 2,
    parameter int DATA_W     = 16,
    parameter int ACT_W      = 2,
    parameter int IDX_W      = 4
);
    logic                              q_valid;
    logic                              q_ready;
    logic [NUM_STATES-1:0][DATA_W-1:0] q_belief;
    logic                              r_valid;
    logic                              r_ready;
    logic [ACT_W-1:0]                  r_action;
    logic [IDX_W-1:0]                  r_index;
`ifdef POLICY_VALUE_OUT_EN
    logic [2*DATA_W:0]                 r_value;
`endif

    modport master (
        output q_valid, q_belief, r_ready,
        input  q_ready, r_valid, r_action, r_index
`ifdef POLICY_VALUE_OUT_EN
        , input r_value
`endif
    );

    modport slave (
        input  q_valid, q_belief, r_ready,
        output q_ready, r_valid, r_action, r_index
`ifdef POLICY_VALUE_OUT_EN
        , output r_value
`endif
    );
endinterface

// File: rtl/policy_lookup.sv
// Argmax dot-product policy lookup over a double-buffered alpha bank.
// POLICY_VALUE_OUT_EN adds the winning value output (r_value).
module policy_lookup #(
    parameter int NUM_POINTS = 16,
    parameter int NUM_STATES = 2,
    parameter int DATA_W     = 16,
    parameter int ACT_W      = 2,
    parameter int IDX_W      = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            load_en,
    input  logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0] alpha_in,
    input  logic [NUM_POINTS-1:0][ACT_W-1:0]                action_in,
    output logic                                            bank_valid,
    output logic                                            busy,
    policy_lookup_if.slave                                  qif
);
    localparam int VAL_W = 2 * DATA_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

    typedef logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0] alpha_bank_t;
    typedef logic [NUM_POINTS-1:0][ACT_W-1:0] act_bank_t;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                            state_q, state_d;
    alpha_bank_t                       alpha_q, alpha_d;
    alpha_bank_t                       shadow_alpha_q, shadow_alpha_d;
    act_bank_t                         act_q, act_d;
    act_bank_t                         shadow_act_q, shadow_act_d;
    logic                              bank_valid_q, bank_valid_d;
    logic                              pend_q, pend_d;
    logic [NUM_STATES-1:0][DATA_W-1:0] belief_q, belief_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [IDX_W-1:0]                  best_idx_q, best_idx_d;
    logic [VAL_W-1:0]                  best_q, best_d;
    logic [VAL_W-1:0]                  dot;
    logic [ACT_W-1:0]                  res_act_q, res_act_d;
    logic [IDX_W-1:0]                  res_idx_q, res_idx_d;
    logic                              scan_end;
    logic                              accept;
`ifdef POLICY_VALUE_OUT_EN
    logic [VAL_W-1:0]                  res_val_q, res_val_d;
`endif

    assign accept   = qif.q_valid && qif.q_ready;
    assign scan_end = (state_q == SCAN) && (idx_q == LAST_IDX);

    always_comb begin
        dot = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            dot = dot + VAL_W'(belief_q[s]) * VAL_W'(alpha_q[idx_q][s]);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        belief_d   = belief_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    belief_d   = qif.q_belief;
                    idx_d      = '0;
                    best_d     = '0;
                    best_idx_d = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // Strict compare: ties keep the lower index.
                if (idx_q == '0 || dot > best_q) begin
                    best_d     = dot;
                    best_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (qif.r_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alpha_d        = alpha_q;
        act_d          = act_q;
        shadow_alpha_d = shadow_alpha_q;
        shadow_act_d   = shadow_act_q;
        pend_d         = pend_q;
        bank_valid_d   = bank_valid_q;
        if (load_en && state_q != SCAN) begin
            alpha_d      = alpha_in;
            act_d        = action_in;
            bank_valid_d = 1'b1;
        end else if (load_en) begin
            shadow_alpha_d = alpha_in;
            shadow_act_d   = action_in;
            pend_d         = 1'b1;
        end
        // A load arriving on the final scan cycle is newer than the shadow.
        if (scan_end) begin
            if (load_en) begin
                alpha_d = alpha_in;
                act_d   = action_in;
            end else if (pend_q) begin
                alpha_d = shadow_alpha_q;
                act_d   = shadow_act_q;
            end
            pend_d = 1'b0;
        end
    end

    always_comb begin
        res_act_d = res_act_q;
        res_idx_d = res_idx_q;
`ifdef POLICY_VALUE_OUT_EN
        res_val_d = res_val_q;
`endif
        if (scan_end) begin
            res_act_d = act_q[best_idx_d];
            res_idx_d = best_idx_d;
`ifdef POLICY_VALUE_OUT_EN
            res_val_d = best_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bank_valid_q <= 1'b0;
            pend_q       <= 1'b0;
            belief_q     <= '0;
            idx_q        <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            res_act_q    <= '0;
            res_idx_q    <= '0;
`ifdef POLICY_VALUE_OUT_EN
            res_val_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bank_valid_q <= bank_valid_d;
            pend_q       <= pend_d;
            belief_q     <= belief_d;
            idx_q        <= idx_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            res_act_q    <= res_act_d;
            res_idx_q    <= res_idx_d;
`ifdef POLICY_VALUE_OUT_EN
            res_val_q    <= res_val_d;
`endif
        end
    end

    // Bank storage survives reset; bank_valid alone gates its use.
    always_ff @(posedge clk) begin
        alpha_q        <= alpha_d;
        act_q          <= act_d;
        shadow_alpha_q <= shadow_alpha_d;
        shadow_act_q   <= shadow_act_d;
    end

    assign bank_valid   = bank_valid_q;
    assign busy         = (state_q == SCAN);
    assign qif.q_ready  = (state_q == IDLE) && bank_valid_q;
    assign qif.r_valid  = (state_q == DONE);
    assign qif.r_action = res_act_q;
    assign qif.r_index  = res_idx_q;
`ifdef POLICY_VALUE_OUT_EN
    assign qif.r_value  = (state_q == DONE) ? res_val_q : '0;
`endif
endmodule

// File: tb/tb_policy_lookup.sv
// Testbench for policy_lookup: vector table plus corner sequences.
// Value checks are compiled in when POLICY_VALUE_OUT_EN is defined.
module tb_policy_lookup;
    localparam int NP = 16;
    localparam int NS = 2;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int IW = 4;

    typedef struct {
        logic [IW-1:0] idx;
        logic [AW-1:0] act;
        logic [2*DW:0] val;
    } exp_t;

    typedef struct {
        logic [DW-1:0] b0;
        logic [DW-1:0] b1;
        exp_t          e;
    } vec_t;

    logic                              clk = 1'b0;
    logic                              rst;
    logic                              load_en;
    logic [NP-1:0][NS-1:0][DW-1:0]     alpha_in;
    logic [NP-1:0][AW-1:0]             action_in;
    logic                              bank_valid;
    logic                              busy;
    int                                errors = 0;
    int                                checks = 0;
    int                                w;
    exp_t                              sb[$];
    vec_t                              tbl[8];

    policy_lookup_if #(.NUM_STATES(NS), .DATA_W(DW), .ACT_W(AW), .IDX_W(IW)) qif ();

    policy_lookup #(
        .NUM_POINTS(NP), .NUM_STATES(NS), .DATA_W(DW), .ACT_W(AW), .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_en(load_en),
        .alpha_in(alpha_in),
        .action_in(action_in),
        .bank_valid(bank_valid),
        .busy(busy),
        .qif(qif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input int idx, input int act, input logic [2*DW:0] val);
        exp_t e;
        e.idx = IW'(idx);
        e.act = AW'(act);
        e.val = val;
        return e;
    endfunction

    function automatic vec_t mkv(input int b0, input int b1, input int idx,
                                 input int act, input logic [2*DW:0] val);
        vec_t v;
        v.b0 = DW'(b0);
        v.b1 = DW'(b1);
        v.e  = mk(idx, act, val);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    // mode 0 concave, 1 linear, 2 flat, 3 spike@2, 4 spike@9, else all-ones
    task automatic load_bank(input int mode);
        for (int i = 0; i < NP; i++) begin
            action_in[i] = AW'(i % 3);
            case (mode)
                0: begin
                    alpha_in[i][0] = DW'(16 * i);
                    alpha_in[i][1] = DW'(256 - i * i);
                end
                1: begin
                    alpha_in[i][0] = DW'(100 * i);
                    alpha_in[i][1] = '0;
                end
                2: begin
                    alpha_in[i][0] = DW'(50);
                    alpha_in[i][1] = DW'(50);
                end
                3: begin
                    alpha_in[i][0] = (i == 2) ? DW'(500) : DW'(100);
                    alpha_in[i][1] = '0;
                end
                4: begin
                    alpha_in[i][0] = (i == 9) ? DW'(700) : DW'(100);
                    alpha_in[i][1] = '0;
                    action_in[i]   = AW'(3);
                end
                default: begin
                    alpha_in[i][0] = '1;
                    alpha_in[i][1] = '1;
                    action_in[i]   = AW'(3);
                end
            endcase
        end
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Returns one cycle after the accept cycle, with q_belief scrambled.
    task automatic start_q(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                           input exp_t e, output int waited);
        qif.q_belief[0] = b0;
        qif.q_belief[1] = b1;
        qif.q_valid     = 1'b1;
        waited = 0;
        while (!qif.q_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!qif.q_ready) begin
            chk("accept_timeout", 64'(waited), 64'(0));
        end else begin
            sb.push_back(e);
        end
        @(negedge clk);
        qif.q_valid  = 1'b0;
        qif.q_belief = '1;
        chk("busy_scan", 64'(busy), 64'(1));
    endtask

    task automatic finish_q(input int lat0, input int hold);
        int   lat;
        exp_t e;
        lat = lat0;
        while (!qif.r_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(NP + 1));
        if (!qif.r_valid) return;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'(0), 64'(1));
            return;
        end
        e = sb.pop_front();
        for (int c = 0; c <= hold; c++) begin
            chk("r_valid", 64'(qif.r_valid), 64'(1));
            chk("r_index", 64'(qif.r_index), 64'(e.idx));
            chk("r_action", 64'(qif.r_action), 64'(e.act));
`ifdef POLICY_VALUE_OUT_EN
            chk("r_value", 64'(qif.r_value), 64'(e.val));
`endif
            chk("q_ready_done", 64'(qif.q_ready), 64'(0));
            if (c < hold) @(negedge clk);
        end
        qif.r_ready = 1'b1;
        @(negedge clk);
        qif.r_ready = 1'b0;
        chk("r_valid_drop", 64'(qif.r_valid), 64'(0));
        chk("q_ready_idle", 64'(qif.q_ready), 64'(1));
    endtask

    initial begin
        rst          = 1'b1;
        load_en      = 1'b0;
        alpha_in     = '0;
        action_in    = '0;
        qif.q_valid  = 1'b0;
        qif.q_belief = '0;
        qif.r_ready  = 1'b0;

        tbl[0] = mkv(1, 1, 8, 2, 33'd320);
        tbl[1] = mkv(1, 2, 4, 1, 33'd544);
        tbl[2] = mkv(3, 2, 12, 0, 33'd800);
        tbl[3] = mkv(1, 4, 2, 2, 33'd1040);
        tbl[4] = mkv(1, 0, 15, 0, 33'd240);
        tbl[5] = mkv(0, 1, 0, 0, 33'd256);
        tbl[6] = mkv(0, 0, 0, 0, 33'd0);
        tbl[7] = mkv(1, 16, 0, 0, 33'd4096);

        repeat (3) @(negedge clk);
        chk("rst_q_ready", 64'(qif.q_ready), 64'(0));
        chk("rst_r_valid", 64'(qif.r_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_bank_valid", 64'(bank_valid), 64'(0));
        chk("rst_r_index", 64'(qif.r_index), 64'(0));
        chk("rst_r_action", 64'(qif.r_action), 64'(0));
`ifdef POLICY_VALUE_OUT_EN
        chk("rst_r_value", 64'(qif.r_value), 64'(0));
`endif
        rst = 1'b0;

        qif.q_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("noload_q_ready", 64'(qif.q_ready), 64'(0));
            chk("noload_r_valid", 64'(qif.r_valid), 64'(0));
        end
        qif.q_valid = 1'b0;

        load_bank(1);
        chk("bank_valid_load", 64'(bank_valid), 64'(1));
        start_q(16'd1, 16'd0, mk(15, 0, 33'd1500), w);
        finish_q(1, 0);

        load_bank(2);
        start_q(16'd3, 16'd7, mk(0, 0, 33'd500), w);
        finish_q(1, 0);

        load_bank(0);
        for (int i = 0; i < 8; i++) begin
            start_q(tbl[i].b0, tbl[i].b1, tbl[i].e, w);
            if (i > 0) chk("back_to_back", 64'(w), 64'(0));
            finish_q(1, 0);
        end

        load_bank(3);
        start_q(16'd1, 16'd1, mk(2, 2, 33'd500), w);
        repeat (4) @(negedge clk);
        load_bank(4);
        finish_q(6, 0);
        start_q(16'd1, 16'd1, mk(9, 3, 33'd700), w);
        finish_q(1, 0);

        start_q(16'd1, 16'd1, mk(9, 3, 33'd700), w);
        finish_q(1, 10);

        load_bank(0);
        start_q(16'd1, 16'd1, mk(8, 2, 33'd320), w);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("abort_r_valid", 64'(qif.r_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_bank_valid", 64'(bank_valid), 64'(0));
        chk("abort_q_ready", 64'(qif.q_ready), 64'(0));
        repeat (20) @(negedge clk);
        chk("abort_no_result", 64'(qif.r_valid), 64'(0));
        load_bank(0);
        start_q(16'd1, 16'd1, mk(8, 2, 33'd320), w);
        finish_q(1, 0);

        load_bank(5);
        start_q(16'hFFFF, 16'hFFFF, mk(0, 3, 33'h1FFFC0002), w);
        finish_q(1, 0);

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
